// File: rtl/bp_perf_monitor.sv
// bp_perf_monitor
//   Compares NUM_CH branch predictors over the same instruction stream. It
//   keeps saturating totals for fetched instructions, resolved branches and
//   per-channel mispredictions. When a nonzero window length L is latched at
//   the start of a run, it also snapshots the per-window branch and miss
//   counts every L enabled cycles into a small FIFO.
// Ports
//   clk_i, rst_i        : clock and synchronous active-high reset
//   en_i, clear_i       : counting enable (IDLE/RUN FSM) and counter clear
//   instr_vld_i         : one instruction fetched this cycle
//   br_instr_i          : one resolved branch this cycle
//   br_miss_i           : per-channel misprediction; counted only with a branch
//   win_len_i           : window length in enabled cycles (0 = no windowing)
//   instr_cnt_o         : total instructions
//   br_cnt_o            : total branches
//   miss_cnt_o          : total misses per channel, packed CNT_WIDTH per channel
//   snap_valid_o        : snapshot FIFO head is valid
//   snap_ready_i        : consumer pops the head
//   snap_br_o           : head snapshot branch count
//   snap_miss_o         : head snapshot per-channel miss counts
//   drop_cnt_o          : snapshots lost to a full FIFO (saturates at 255)
//   sat_o               : sticky flag, some counter reached all-ones
module bp_perf_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int WIN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        clear_i,
  input  logic                        instr_vld_i,
  input  logic                        br_instr_i,
  input  logic [NUM_CH-1:0]           br_miss_i,
  input  logic [WIN_WIDTH-1:0]        win_len_i,
  output logic [CNT_WIDTH-1:0]        instr_cnt_o,
  output logic [CNT_WIDTH-1:0]        br_cnt_o,
  output logic [NUM_CH*CNT_WIDTH-1:0] miss_cnt_o,
  output logic                        snap_valid_o,
  input  logic                        snap_ready_i,
  output logic [CNT_WIDTH-1:0]        snap_br_o,
  output logic [NUM_CH*CNT_WIDTH-1:0] snap_miss_o,
  output logic [7:0]                  drop_cnt_o,
  output logic                        sat_o
);

  localparam int                   PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]       FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [0:0]           IDLE     = 1'b0;
  localparam logic [0:0]           RUN      = 1'b1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val,
                                                   input logic ev);
    return (ev && (val != CNT_MAX)) ? val + 1'b1 : val;
  endfunction

  logic [0:0]                  state_reg, state_next;
  logic [WIN_WIDTH-1:0]        win_len_reg, win_len_eff, cyc_reg;
  logic                        count_en, win_on, win_last, acc_clr, br_ev;
  logic [NUM_CH-1:0]           sat_ch;
  logic [CNT_WIDTH-1:0]        instr_cnt_reg, instr_cnt_next;
  logic [CNT_WIDTH-1:0]        br_cnt_reg, br_cnt_next;
  logic [CNT_WIDTH-1:0]        acc_br_reg, acc_br_sum;
  logic [NUM_CH*CNT_WIDTH-1:0] snap_miss_in;
  logic [7:0]                  drop_reg, drop_next;
  logic                        sat_reg, sat_hit;

  logic [CNT_WIDTH-1:0]        mem_br [FIFO_DEPTH];
  logic [NUM_CH*CNT_WIDTH-1:0] mem_miss [FIFO_DEPTH];
  logic [PTR_W-1:0]            rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]              fill_reg;
  logic                        fifo_full, pop, push_req, push_ok;

  // FSM: the cycle that raises en_i already counts, so the effective enable
  // is simply en_i (clear_i suppresses that cycle's events).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en_i)  state_next = RUN;
      default: if (!en_i) state_next = IDLE;
    endcase
  end

  assign count_en = en_i && !clear_i;
  assign br_ev    = count_en && br_instr_i;

  // In IDLE the length being latched this cycle already governs the first window.
  assign win_len_eff = (state_reg == IDLE) ? win_len_i : win_len_reg;
  assign win_on      = (win_len_eff != '0);
  assign win_last    = count_en && win_on && (cyc_reg == win_len_eff - 1'b1);
  // Accumulators restart after a push, and are discarded when en_i drops.
  assign acc_clr     = !count_en || !win_on || win_last;

  assign instr_cnt_next = sat_inc(instr_cnt_reg, count_en && instr_vld_i);
  assign br_cnt_next    = sat_inc(br_cnt_reg, br_ev);
  assign acc_br_sum     = sat_inc(acc_br_reg, br_ev);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                 miss_ev;
      logic [CNT_WIDTH-1:0] miss_cnt_reg, miss_cnt_next, acc_miss_reg, acc_miss_sum;

      assign miss_ev       = br_ev && br_miss_i[gi];
      assign miss_cnt_next = sat_inc(miss_cnt_reg, miss_ev);
      assign acc_miss_sum  = sat_inc(acc_miss_reg, miss_ev);
      assign sat_ch[gi]    = (miss_cnt_next == CNT_MAX) ||
                             (count_en && win_on && (acc_miss_sum == CNT_MAX));
      assign snap_miss_in[gi*CNT_WIDTH +: CNT_WIDTH] = acc_miss_sum;
      assign miss_cnt_o[gi*CNT_WIDTH +: CNT_WIDTH]   = miss_cnt_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          miss_cnt_reg <= '0;
          acc_miss_reg <= '0;
        end else begin
          miss_cnt_reg <= miss_cnt_next;
          acc_miss_reg <= acc_clr ? '0 : acc_miss_sum;
        end
      end
    end
  endgenerate

  // Snapshot FIFO: a push into a full FIFO is still accepted if the head is
  // popped in the same cycle (the write lands in the slot being vacated).
  assign pop       = snap_valid_o && snap_ready_i;
  assign fifo_full = (fill_reg == FULL_LVL);
  assign push_req  = win_last;
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop_next = (push_req && !push_ok && (drop_reg != 8'hFF)) ? drop_reg + 1'b1 : drop_reg;

  assign sat_hit = (instr_cnt_next == CNT_MAX) || (br_cnt_next == CNT_MAX) ||
                   (count_en && win_on && (acc_br_sum == CNT_MAX)) ||
                   (|sat_ch) || (drop_next == 8'hFF);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      win_len_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && en_i) win_len_reg <= win_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      instr_cnt_reg <= '0;
      br_cnt_reg    <= '0;
      acc_br_reg    <= '0;
      cyc_reg       <= '0;
      drop_reg      <= '0;
      sat_reg       <= 1'b0;
    end else begin
      instr_cnt_reg <= instr_cnt_next;
      br_cnt_reg    <= br_cnt_next;
      acc_br_reg    <= acc_clr ? '0 : acc_br_sum;
      cyc_reg       <= acc_clr ? '0 : cyc_reg + 1'b1;
      drop_reg      <= drop_next;
      sat_reg       <= sat_reg || sat_hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_br[i]   <= '0;
        mem_miss[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_br[wr_ptr_reg]   <= acc_br_sum;
        mem_miss[wr_ptr_reg] <= snap_miss_in;
        wr_ptr_reg           <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  assign instr_cnt_o  = instr_cnt_reg;
  assign br_cnt_o     = br_cnt_reg;
  assign drop_cnt_o   = drop_reg;
  assign sat_o        = sat_reg;
  assign snap_valid_o = (fill_reg != '0);
  assign snap_br_o    = mem_br[rd_ptr_reg];
  assign snap_miss_o  = mem_miss[rd_ptr_reg];

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed bench for bp_perf_monitor: a default-width instance plus a
// CNT_WIDTH=4 instance on the same stimulus for saturation checks.
module tb_bp_perf_monitor;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int CWS = 4;
  localparam int WW  = 16;

  logic           clk = 1'b0;
  logic           rst, en, clr, ivld, bri, rdy;
  logic [NCH-1:0] miss;
  logic [WW-1:0]  wl;

  logic [CW-1:0]      instr_o, br_o, snap_br;
  logic [NCH*CW-1:0]  miss_o, snap_miss;
  logic               snap_valid, sat;
  logic [7:0]         drop;

  logic [CWS-1:0]     instr_s, br_s, snap_br_s;
  logic [NCH*CWS-1:0] miss_s, snap_miss_s;
  logic               snap_valid_s, sat_s;
  logic [7:0]         drop_s;

  int total = 0;
  int bad   = 0;

  bp_perf_monitor #(.NUM_CH(NCH), .CNT_WIDTH(CW), .WIN_WIDTH(WW), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .instr_vld_i(ivld),
    .br_instr_i(bri), .br_miss_i(miss), .win_len_i(wl),
    .instr_cnt_o(instr_o), .br_cnt_o(br_o), .miss_cnt_o(miss_o),
    .snap_valid_o(snap_valid), .snap_ready_i(rdy), .snap_br_o(snap_br),
    .snap_miss_o(snap_miss), .drop_cnt_o(drop), .sat_o(sat)
  );

  bp_perf_monitor #(.NUM_CH(NCH), .CNT_WIDTH(CWS), .WIN_WIDTH(WW), .FIFO_DEPTH(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .instr_vld_i(ivld),
    .br_instr_i(bri), .br_miss_i(miss), .win_len_i(wl),
    .instr_cnt_o(instr_s), .br_cnt_o(br_s), .miss_cnt_o(miss_s),
    .snap_valid_o(snap_valid_s), .snap_ready_i(rdy), .snap_br_o(snap_br_s),
    .snap_miss_o(snap_miss_s), .drop_cnt_o(drop_s), .sat_o(sat_s)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] ch(input logic [NCH*CW-1:0] v, input int k);
    return v[k*CW +: CW];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; ivld = 1'b0; bri = 1'b0; rdy = 1'b0;
    miss = '0; wl = '0;
    tick(2);
    rst = 1'b0;

    // reset state
    chk("rst_instr", instr_o, 0);
    chk("rst_br", br_o, 0);
    chk("rst_miss", miss_o, 0);
    chk("rst_valid", snap_valid, 0);
    chk("rst_snap_br", snap_br, 0);
    chk("rst_drop", drop, 0);
    chk("rst_sat", sat, 0);
    chk("rst_s_all", {instr_s, miss_s, snap_valid_s, snap_br_s, snap_miss_s, drop_s}, 0);

    // 10 branches, 0101 misses on 3 of them; stray miss without branch; en low cycle
    wl = '0; en = 1'b1; ivld = 1'b1; bri = 1'b1;
    for (int i = 0; i < 10; i++) begin
      miss = (i < 3) ? 4'b0101 : 4'b0000;
      tick();
    end
    bri = 1'b0; ivld = 1'b0; miss = 4'b1111;
    tick();
    en = 1'b0; bri = 1'b1; ivld = 1'b1; miss = 4'b0101;
    tick();
    bri = 1'b0; ivld = 1'b0; miss = '0;
    chk("t1_br", br_o, 10);
    chk("t1_instr", instr_o, 10);
    chk("t1_ch0", ch(miss_o, 0), 3);
    chk("t1_ch1", ch(miss_o, 1), 0);
    chk("t1_ch2", ch(miss_o, 2), 3);
    chk("t1_ch3", ch(miss_o, 3), 0);

    // L=8 windows, branch and ch0 miss every cycle, consumer always ready
    do_reset();
    wl = 16'd8; en = 1'b1; bri = 1'b1; miss = 4'b0001; rdy = 1'b1;
    tick(8);
    chk("t2_w1_valid", snap_valid, 1);
    chk("t2_w1_br", snap_br, 8);
    chk("t2_w1_ch0", ch(snap_miss, 0), 8);
    chk("t2_w1_ch1", ch(snap_miss, 1), 0);
    tick();
    chk("t2_popped", snap_valid, 0);
    tick(7);
    chk("t2_w2_valid", snap_valid, 1);
    chk("t2_w2_br", snap_br, 8);
    chk("t2_w2_ch0", ch(snap_miss, 0), 8);
    chk("t2_tot_br", br_o, 16);
    en = 1'b0; bri = 1'b0; miss = '0;
    tick();

    // L=4, no consumer for 6 windows, then push into full FIFO with a pop
    do_reset();
    rdy = 1'b0; wl = 16'd4; en = 1'b1; bri = 1'b1; miss = '0;
    tick(24);
    chk("t3_full_valid", snap_valid, 1);
    chk("t3_drop2", drop, 2);
    chk("t3_head_br", snap_br, 4);
    miss = 4'b0010;
    tick(3);
    rdy = 1'b1;
    tick();
    chk("t3_pushpop_drop", drop, 2);
    chk("t3_pushpop_valid", snap_valid, 1);
    en = 1'b0; bri = 1'b0; miss = '0;
    tick(3);
    chk("t3_w7_valid", snap_valid, 1);
    chk("t3_w7_ch1", ch(snap_miss, 1), 4);
    chk("t3_w7_br", snap_br, 4);
    tick();
    chk("t3_empty", snap_valid, 0);
    rdy = 1'b0;

    // 4-bit counters saturate at 15; clear zeroes them and sat
    do_reset();
    wl = '0; en = 1'b1; bri = 1'b1;
    tick(20);
    chk("t4_s_br", br_s, 15);
    chk("t4_s_sat", sat_s, 1);
    chk("t4_br", br_o, 20);
    chk("t4_sat", sat, 0);
    clr = 1'b1;
    tick();
    chk("t4_s_clr_br", br_s, 0);
    chk("t4_s_clr_sat", sat_s, 0);
    chk("t4_clr_br", br_o, 0);
    clr = 1'b0; en = 1'b0; bri = 1'b0;
    tick();

    // en dropped on cycle 5 of an L=8 window discards it; clear beats a branch
    do_reset();
    rdy = 1'b0; wl = 16'd8; en = 1'b1; bri = 1'b1;
    tick(4);
    en = 1'b0;
    tick(3);
    chk("t5_no_push", snap_valid, 0);
    chk("t5_br4", br_o, 4);
    en = 1'b1;
    tick(4);
    chk("t5_partial_gone", snap_valid, 0);
    tick(4);
    chk("t5_full_win_valid", snap_valid, 1);
    chk("t5_full_win_br", snap_br, 8);
    chk("t5_br12", br_o, 12);
    clr = 1'b1;
    tick();
    chk("t5_clr_br", br_o, 0);
    chk("t5_clr_fifo_kept", snap_valid, 1);
    chk("t5_clr_snap_br", snap_br, 8);
    clr = 1'b0; en = 1'b0; bri = 1'b0;
    tick();

    // reset with 3 FIFO entries, nonzero counters, mid-handshake
    do_reset();
    rdy = 1'b0; wl = 16'd2; en = 1'b1; bri = 1'b1; ivld = 1'b1; miss = 4'b0101;
    tick(6);
    chk("t6_pre_valid", snap_valid, 1);
    chk("t6_pre_br", br_o, 6);
    chk("t6_pre_snap_ch0", ch(snap_miss, 0), 2);
    rst = 1'b1; rdy = 1'b1; clr = 1'b1;
    tick();
    chk("t6_valid", snap_valid, 0);
    chk("t6_counts", {instr_o, br_o, miss_o}, 0);
    chk("t6_snap", {snap_br, snap_miss}, 0);
    chk("t6_drop_sat", {drop, sat}, 0);
    rst = 1'b0; clr = 1'b0; en = 1'b0; bri = 1'b0; ivld = 1'b0; miss = '0; rdy = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
